// File: rtl/mem_sram_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller.
// State encoding and the data-memory base address.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } mem_state_t;

    localparam int DATA_MEM_BASE = 1024;

endpackage

// File: rtl/mem_sram_access_ctrl_wait_counter.sv
// Wait-state counter for one SRAM halfword phase.
// tc flags the last clock of a phase (count == WAIT_CYCLES-1).
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_sram_access_ctrl.sv
// 32-bit load/store over a 16-bit SRAM as two halfword phases.
// Freezes the pipeline (ready=0) until the word access completes.
module mem_sram_access_ctrl
    import arm_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = DATA_MEM_BASE,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int WW = SRAM_AW - 1;

    mem_state_t    state;
    logic          wr_q;
    logic [WW-1:0] w_q;
    logic [31:0]   wdata_q;
    logic          busy;
    logic          tc;
    logic          req;
    logic [31:0]   widx;
    logic [WW-1:0] w_next;

    assign req    = mem_r_en | mem_w_en;
    assign widx   = (addr - 32'(ADDR_BASE)) >> 2;
    assign w_next = WW'(widx);
    assign busy   = (state == LO) || (state == HI);

    // Freeze in the request cycle itself so EXE->MEM does not advance.
    assign ready = (state == IDLE) ? ~req : (state == DONE);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk(clk),
        .rst(rst),
        .clr(~busy | tc),
        .en (busy),
        .tc (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            w_q         <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        wr_q      <= mem_w_en;
                        w_q       <= w_next;
                        wdata_q   <= wdata;
                        sram_addr <= {w_next, 1'b0};
                        if (mem_w_en) begin
                            sram_we_n   <= 1'b0;
                            sram_dq_oe  <= 1'b1;
                            sram_dq_out <= wdata[15:0];
                        end else begin
                            sram_oe_n <= 1'b0;
                        end
                        state <= LO;
                    end
                end
                LO: begin
                    if (tc) begin
                        sram_addr <= {w_q, 1'b1};
                        if (wr_q) begin
                            sram_dq_out <= wdata_q[31:16];
                        end else begin
                            rdata[15:0] <= sram_dq_in;
                        end
                        state <= HI;
                    end
                end
                HI: begin
                    if (tc) begin
                        if (!wr_q) begin
                            rdata[31:16] <= sram_dq_in;
                        end
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sram_access_ctrl.sv
// Bench for mem_sram_access_ctrl: SRAM device model plus a
// halfword-level reference memory of what should be stored.
module tb_mem_sram_access_ctrl;

    localparam int W    = 2;
    localparam int AW   = 18;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_r_en = 1'b0;
    logic          mem_w_en = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_in;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic          sram_we_n;
    logic          sram_oe_n;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] sram_mem [0:(1<<AW)-1];
    logic [15:0] refh [int];
    logic [31:0] rd_exp = '0;

    always #5 clk = ~clk;

    mem_sram_access_ctrl #(
        .WAIT_CYCLES(W),
        .ADDR_BASE  (1024),
        .SRAM_AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_in (sram_dq_in),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    // External SRAM device: garbage on the bus when not output-enabled.
    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe)
            sram_mem[sram_addr] <= sram_dq_out;

    assign sram_dq_in = !sram_oe_n ? sram_mem[sram_addr] : 16'hA5A5;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_rd(input int unsigned hw);
        return refh.exists(int'(hw)) ? refh[int'(hw)] : 16'h0;
    endfunction

    function automatic int unsigned hw_of(input logic [31:0] a,
                                          input int half);
        int unsigned off;
        off = a - 32'd1024;
        return (((off >> 2) << 1) | half) & MASK;
    endfunction

    // One load/store as seen by the MEM stage. Called at a negedge;
    // from_done: DUT is in DONE of the previous access (enables held).
    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit from_done,
                          input bit hold);
        int  lowc;
        int  stc;
        int  half;
        bit  done;
        bit  is_wr;
        is_wr    = w;
        mem_r_en = r;
        mem_w_en = w;
        addr     = a;
        wdata    = d;
        if (from_done) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
        chk("req_ready", ready, 0);
        chk("idle_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
        lowc = 1;
        stc  = 0;
        done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk);
            #1;
            addr  = $urandom;
            wdata = $urandom;
            if (ready) begin
                done = 1;
            end else begin
                lowc++;
                half = (stc / W) & 1;
                chk("sram_addr", sram_addr, hw_of(a, half));
                if (is_wr) begin
                    chk("wr_we_n", sram_we_n, 0);
                    chk("wr_oe_n", sram_oe_n, 1);
                    chk("wr_dq_oe", sram_dq_oe, 1);
                    chk("wr_dq_out", sram_dq_out,
                        half ? d[31:16] : d[15:0]);
                end else begin
                    chk("rd_oe_n", sram_oe_n, 0);
                    chk("rd_we_n", sram_we_n, 1);
                    chk("rd_dq_oe", sram_dq_oe, 0);
                end
                stc++;
            end
        end
        if (!done) chk("timeout", 0, 1);
        chk("freeze_len", lowc, 1 + 2 * W);
        chk("done_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
        if (is_wr) begin
            refh[int'(hw_of(a, 0))] = d[15:0];
            refh[int'(hw_of(a, 1))] = d[31:16];
        end else begin
            rd_exp = {ref_rd(hw_of(a, 1)), ref_rd(hw_of(a, 0))};
        end
        chk("rdata", rdata, rd_exp);
        @(negedge clk);
        if (!hold) begin
            mem_r_en = 0;
            mem_w_en = 0;
            @(posedge clk);
            #1;
            chk("post_ready", ready, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int  act;
        bit  prev_hold;
        bit  op_w;
        bit  hold;
        logic [31:0] a;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_rdata", rdata, 0);
        chk("rst_strobes", {sram_we_n, sram_oe_n, sram_dq_oe}, 3'b110);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        @(negedge clk);
        rst = 0;

        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!sram_we_n || !sram_oe_n || sram_dq_oe || !ready) act++;
        end
        chk("idle_activity", act, 0);
        @(negedge clk);

        access(0, 1, 32'd1032, 32'hDEADBEEF, 0, 0);
        access(1, 0, 32'd1032, 32'h0, 0, 0);

        access(0, 1, 32'd1036, 32'h0BADF00D, 0, 1);
        access(1, 0, 32'd1036, 32'h0, 1, 1);
        mem_r_en = 0;
        act = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (!sram_we_n || !sram_oe_n || !ready) act++;
        end
        chk("no_reissue", act, 0);
        @(negedge clk);

        // Reset in the HI phase of a write: low half only is stored.
        mem_w_en = 1;
        addr     = 32'd1040;
        wdata    = 32'hCAFEF00D;
        repeat (1 + W) @(posedge clk);
        #1;
        chk("hi_reached", sram_addr, hw_of(32'd1040, 1));
        mem_w_en = 0;
        rst      = 1;
        #1;
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_addr", sram_addr, 0);
        refh[int'(hw_of(32'd1040, 0))] = 16'hF00D;
        rd_exp = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        access(1, 0, 32'd1040, 32'h0, 0, 0);

        access(1, 1, 32'd1024, 32'h12345678, 0, 0);
        access(1, 0, 32'd1024, 32'h0, 0, 0);

        // Out-of-range index wraps onto halfwords 4/5.
        access(1, 0, 32'd1024 + (32'd1 << 19) + 32'd8, 32'h0, 0, 0);

        prev_hold = 0;
        for (int i = 0; i < 24; i++) begin
            a    = 32'd1024 + 4 * $urandom_range(0, 15);
            op_w = $urandom_range(0, 1);
            hold = (i != 23) && ($urandom_range(0, 1) == 1);
            access(!op_w, op_w, a, $urandom, prev_hold, hold);
            prev_hold = hold;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
